alu_md: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU.
- Keeps same-cycle combinational ops (arithmetic, logic, compare, shift) and adds an iterative multiply/divide engine with architectural HI/LO registers.
- Sits in the EX stage. The control unit stalls the pipeline while busy is high.

---
 rtl/ctrl_encode_def.sv | 35 +++
 rtl/alu_muldiv_iter.sv | 124 ++++++++++++
 rtl/alu_md.sv | 79 +++++++
 tb/tb_alu_md.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_encode_def.sv
// ALUOp codes and mult/div FSM state encodings shared by alu_md and its
// iterative mult/div engine.
package ctrl_encode_def;

  localparam int unsigned OP_ADDU  = 0;
  localparam int unsigned OP_SUBU  = 1;
  localparam int unsigned OP_ADD   = 2;
  localparam int unsigned OP_SUB   = 3;
  localparam int unsigned OP_AND   = 4;
  localparam int unsigned OP_OR    = 5;
  localparam int unsigned OP_XOR   = 6;
  localparam int unsigned OP_NOR   = 7;
  localparam int unsigned OP_SLT   = 8;
  localparam int unsigned OP_SLTU  = 9;
  localparam int unsigned OP_SLL   = 10;
  localparam int unsigned OP_SRL   = 11;
  localparam int unsigned OP_SRA   = 12;
  localparam int unsigned OP_LUI   = 13;
  localparam int unsigned OP_MFHI  = 14;
  localparam int unsigned OP_MFLO  = 15;
  localparam int unsigned OP_MTHI  = 16;
  localparam int unsigned OP_MTLO  = 17;
  localparam int unsigned OP_MULT  = 18;
  localparam int unsigned OP_MULTU = 19;
  localparam int unsigned OP_DIV   = 20;
  localparam int unsigned OP_DIVU  = 21;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider that owns the HI/LO
// registers. Works on magnitudes and applies the result signs when writing HI/LO.
module alu_muldiv_iter
  import ctrl_encode_def::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t               state, state_next;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [WIDTH-1:0]     opnd;
  logic                 neg_hi, neg_lo;
  logic                 is_mul, is_div, is_signed, last;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     res_hi, res_lo;

  assign is_mul    = (op == OP_W'(OP_MULT)) || (op == OP_W'(OP_MULTU));
  assign is_div    = (op == OP_W'(OP_DIV))  || (op == OP_W'(OP_DIVU));
  assign is_signed = (op == OP_W'(OP_MULT)) || (op == OP_W'(OP_DIV));
  assign mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
  assign last      = (count == CNT_W'(WIDTH - 1));
  assign busy      = (state == S_MUL) || (state == S_DIV);
  assign done      = (state == S_FIN);

  // acc: multiply = {partial product, remaining multiplier bits};
  //      divide   = {partial remainder, dividend bits / quotient bits}
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    acc_next  = acc;
    if (state == S_MUL) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      if (div_trial[WIDTH]) acc_next = {acc[2*WIDTH-2:0], 1'b0};
      else                  acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    prod_fix = neg_lo ? -acc_next : acc_next;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (state == S_DIV) begin
      res_lo = neg_lo ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
      res_hi = neg_hi ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && is_mul)      state_next = S_MUL;
        else if (start && is_div) state_next = (b == '0) ? S_FIN : S_DIV;
      end
      S_MUL, S_DIV: if (last) state_next = S_FIN;
      S_FIN:        state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      case (state)
        S_IDLE: begin
          if (start && (is_mul || is_div)) begin
            count  <= '0;
            neg_lo <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi <= is_signed && a[WIDTH-1];
            acc    <= {{WIDTH{1'b0}}, is_mul ? mag_b : mag_a};
            opnd   <= is_mul ? mag_a : mag_b;
            // divide by zero finishes immediately with a fixed result
            if (is_div && (b == '0)) begin
              hi <= a;
              lo <= '1;
            end
          end else if (start && (op == OP_W'(OP_MTHI))) begin
            hi <= a;
          end else if (start && (op == OP_W'(OP_MTLO))) begin
            lo <= a;
          end
        end
        S_MUL, S_DIV: begin
          count <= count + CNT_W'(1);
          if (last) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: single-cycle combinational ops plus the iterative mult/div
// engine with HI/LO registers.
module alu_md
  import ctrl_encode_def::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  ALUOp,
  input  logic [4:0]       shamt,
  input  logic             start,
  output logic [WIDTH-1:0] C,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] sum, diff;

  assign sum  = A + B;
  assign diff = A + ~B + ONE;
  assign Zero = (A == B);

  always_comb begin
    C        = '0;
    Overflow = 1'b0;
    case (ALUOp)
      OP_W'(OP_ADDU): C = sum;
      OP_W'(OP_SUBU): C = diff;
      OP_W'(OP_ADD): begin
        C        = sum;
        Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_W'(OP_SUB): begin
        C        = diff;
        Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_W'(OP_AND):  C = A & B;
      OP_W'(OP_OR):   C = A | B;
      OP_W'(OP_XOR):  C = A ^ B;
      OP_W'(OP_NOR):  C = ~(A | B);
      OP_W'(OP_SLT):  C = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_W'(OP_SLTU): C = {{(WIDTH-1){1'b0}}, A < B};
      OP_W'(OP_SLL):  C = B << shamt;
      OP_W'(OP_SRL):  C = B >> shamt;
      OP_W'(OP_SRA):  C = $signed(B) >>> shamt;
      OP_W'(OP_LUI):  C = B << (WIDTH / 2);
      OP_W'(OP_MFHI): C = hi;
      OP_W'(OP_MFLO): C = lo;
      default: ;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (ALUOp),
    .a     (A),
    .b     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH=32): arithmetic reference model,
// directed literal checks and a randomized phase.
module tb_alu_md;
  import ctrl_encode_def::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B, C, hi, lo;
  logic [4:0]  ALUOp, shamt;
  logic        start, Zero, Overflow, busy, done;

  int checks = 0;
  int errors = 0;

  alu_md #(.WIDTH(32), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALUOp(ALUOp), .shamt(shamt),
    .start(start), .C(C), .Zero(Zero), .Overflow(Overflow), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_busy_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  function automatic bit is_md(input logic [4:0] op);
    return op == 5'(OP_MULT) || op == 5'(OP_MULTU) || op == 5'(OP_DIV) || op == 5'(OP_DIVU);
  endfunction

  function automatic void md_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0; rl = '0; p = '0; q = 0; r = 0;
    if (op == 5'(OP_MULT)) begin
      p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0];
    end else if (op == 5'(OP_MULTU)) begin
      p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0];
    end else if (b == 0) begin
      rh = a; rl = 32'hFFFF_FFFF;
    end else if (op == 5'(OP_DIV)) begin
      q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0];
    end else begin
      rl = a / b; rh = a % b;
    end
  endfunction

  function automatic logic [31:0] exp_c(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] sh, input logic [31:0] h, input logic [31:0] l);
    longint t;
    case (op)
      5'(OP_ADDU), 5'(OP_ADD): return a + b;
      5'(OP_SUBU), 5'(OP_SUB): return a - b;
      5'(OP_AND):  return a & b;
      5'(OP_OR):   return a | b;
      5'(OP_XOR):  return a ^ b;
      5'(OP_NOR):  return ~(a | b);
      5'(OP_SLT):  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      5'(OP_SLTU): return (a < b) ? 32'd1 : 32'd0;
      5'(OP_SLL):  return b << sh;
      5'(OP_SRL):  return b >> sh;
      5'(OP_SRA):  begin t = longint'($signed(b)) >>> sh; return t[31:0]; end
      5'(OP_LUI):  return {b[15:0], 16'h0000};
      5'(OP_MFHI): return h;
      5'(OP_MFLO): return l;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic bit exp_ov(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op == 5'(OP_ADD))      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 5'(OP_SUB)) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
      end
    end else if (start) begin
      if (is_md(ALUOp)) begin
        md_ref(ALUOp, A, B, p_hi, p_lo);
        if ((ALUOp == 5'(OP_DIV) || ALUOp == 5'(OP_DIVU)) && B == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end else begin
          m_busy_left = W;
        end
      end else if (ALUOp == 5'(OP_MTHI)) begin
        m_hi = A;
      end else if (ALUOp == 5'(OP_MTLO)) begin
        m_lo = A;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("C", C, exp_c(ALUOp, A, B, shamt, m_hi, m_lo));
    chk("Zero", 32'(Zero), 32'(A == B));
    chk("Overflow", 32'(Overflow), 32'(exp_ov(ALUOp, A, B)));
    if (done) $display("txn md_done hi=%h lo=%h", hi, lo);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic st);
    @(posedge clk); #2;
    ALUOp = 5'(op); A = a; B = b; shamt = sh; start = st;
  endtask

  task automatic wait_done(input string name, output int nbusy, output int nwait);
    bit seen;
    seen = 1'b0; nbusy = 0; nwait = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      nwait++;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_md(input string name, input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int ebusy);
    int nb, nw;
    drive(op, a, b, 5'd0, 1'b1);
    drive(op, a, b, 5'd0, 1'b0);
    wait_done(name, nb, nw);
    chk({name, "_busy_cycles"}, 32'(nb), 32'(ebusy));
    chk({name, "_done_cycle"}, 32'(nw), 32'(ebusy + 1));
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    $display("txn %s a=%h b=%h hi=%h lo=%h busy_cycles=%0d", name, a, b, hi, lo, nb);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb, nw, ndone;
    rst_n = 1'b0; A = '0; B = '0; ALUOp = '0; shamt = '0; start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_hi", hi, 32'h0); chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0); chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0); #1;
    chk("add_C", C, 32'h8000_0000); chk("add_ov", 32'(Overflow), 32'd1);
    $display("txn ADD C=%h ov=%b", C, Overflow);
    drive(OP_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0); #1;
    chk("addu_ov", 32'(Overflow), 32'd0);
    drive(OP_SUB, 32'h8000_0000, 32'h1, 5'd0, 1'b0); #1;
    chk("sub_C", C, 32'h7FFF_FFFF); chk("sub_ov", 32'(Overflow), 32'd1);

    run_md("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32);
    run_md("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 32);
    run_md("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
    run_md("divu",  OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 32);
    run_md("divu0", OP_DIVU,  32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 0);
    run_md("divmin", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32);

    // start pulses during an iteration must be dropped
    drive(OP_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1);
    drive(OP_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0);
    repeat (4) @(posedge clk);
    drive(OP_DIV, 32'd100, 32'd7, 5'd0, 1'b1);
    drive(OP_MTHI, 32'h1234, 32'd0, 5'd0, 1'b1);
    drive(OP_MTHI, 32'h1234, 32'd0, 5'd0, 1'b0);
    wait_done("mult_ign", nb, nw);
    chk("mult_ign_hi", hi, 32'hFFFF_FFFF); chk("mult_ign_lo", lo, 32'hFFFF_FFFA);
    drive(OP_MTLO, 32'hABCD, 32'd0, 5'd0, 1'b1);
    drive(OP_MTLO, 32'hABCD, 32'd0, 5'd0, 1'b0);
    drive(OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b0); #1;
    chk("mtlo_lo", lo, 32'hABCD); chk("mflo_C", C, 32'hABCD);
    $display("txn MTLO/MFLO C=%h", C);

    // reset in the middle of a multiply
    drive(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1);
    drive(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0);
    repeat (9) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("abort_busy", 32'(busy), 32'd0); chk("abort_hi", hi, 32'd0); chk("abort_lo", lo, 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    drive(OP_SRA, 32'd0, 32'h8000_0000, 5'd4, 1'b0); #1;
    chk("sra_C", C, 32'hF800_0000);
    drive(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd0, 1'b0); #1;
    chk("sltu_C", C, 32'd1);
    drive(OP_LUI, 32'd0, 32'h0000_BEEF, 5'd0, 1'b0); #1;
    chk("lui_C", C, 32'hBEEF_0000);

    // randomized phase, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 99) < 30) ALUOp = 5'(OP_MULT + $urandom_range(0, 3));
      else                            ALUOp = 5'($urandom_range(0, 31));
      A     = pick();
      B     = pick();
      shamt = 5'($urandom_range(0, 31));
      start = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1; start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
